reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Sequences reset release across the Tx datapath stages: LED driver/DAC, then modulator, then packet framer.
- Combines the board system reset with a debounced user reset button.
- Releases per-stage active-low resets one at a time, waiting for each stage's ready acknowledge.
- Re-sequences on user reset, ack timeout or loss of ready; replaces the plain combinational reset merge at the Tx top level.

Parameters:
- N_STAGES, 3, number of sequenced reset domains; stage 0 is released first.
- DEBOUNCE_CYCLES, 1000000, cycles user_rst must be stable to change its debounced level (10 ms at 100 MHz).
- HOLD_CYCLES, 16, minimum cycles all stage resets stay asserted in HOLD.
- STAGE_GAP, 8, idle cycles after a stage acks, before the next release.
- ACK_TIMEOUT, 4096, cycles allowed for stage_ready[k] after releasing stage k.

Ports:
- clk  in  1  system clock.
- sys_rstn  in  1  system reset; asynchronous, active-low.
- user_rst  in  1  raw user reset button, active-high, asynchronous to clk.
- stage_ready  in  N_STAGES  per-stage ready/init-done, synchronous to clk.
- stage_rstn_out  out  N_STAGES  per-stage active-low resets.
- all_ready  out  1  high only in RUN.
- busy  out  1  high in every state except RUN.
- timeout_err  out  1  sticky; set on any ack timeout.
- retry_cnt  out  4  saturating count of re-sequences since sys_rstn.

Behaviour:
- Reset
  - sys_rstn low asynchronously forces: stage_rstn_out=0, all_ready=0, busy=1, timeout_err=0, retry_cnt=0, FSM=HOLD, all counters=0.
  - sys_rstn deassertion passes through an internal 2-flop reset synchroniser. The FSM advances from the 2nd rising clk edge after sys_rstn rises.
- user_rst conditioning
  - 2-flop synchroniser, then a debounce counter.
  - user_db changes level only after the synchronised input differs from user_db for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
  - user_db resets to 0.
- FSM states: HOLD, RELEASE, WAIT_ACK, GAP, RUN. k is a stage index register.
- HOLD
  - All stage_rstn_out=0; k=0.
  - Counts HOLD_CYCLES. Exit to RELEASE only when count done AND user_db=0. The count does not restart while waiting for user_db.
- RELEASE (1 cycle)
  - Sets stage_rstn_out[k]=1, registered, so visible the cycle after entry.
  - Clears the timeout counter; goes to WAIT_ACK.
- WAIT_ACK
  - stage_ready[k]=1 -> GAP.
  - Timeout counter reaching ACK_TIMEOUT-1 without ack -> set timeout_err, retry_cnt+1 (saturate at 15), go to HOLD.
  - Ack and timeout on the same cycle: ack wins.
- GAP
  - Counts STAGE_GAP cycles.
  - Then, if k==N_STAGES-1 -> RUN; else k+1 -> RELEASE.
  - STAGE_GAP=0 means no gap cycles.
- RUN
  - all_ready=1, busy=0.
  - Any stage_ready bit dropping to 0 -> HOLD, retry_cnt+1.
- Ready monitoring before RUN
  - In WAIT_ACK and GAP, a drop of stage_ready for any already-released stage j<k -> HOLD, retry_cnt+1.
- user_db rising edge in any state
  - HOLD next cycle; all stage_rstn_out=0 on the following registered update. retry_cnt is not incremented.
  - Takes priority over every other transition.
- Release ordering
  - Stages are strictly monotonic: stage j>k is never released before stage k acks.
  - Going to HOLD asserts all stage resets together, same cycle.
- Clearing: timeout_err and retry_cnt are cleared only by sys_rstn.
- Outputs: all outputs registered; no combinational path from inputs to outputs.
- Width rules: counter widths are $clog2(max parameter + 1); k is $clog2(N_STAGES) bits, minimum 1.

Decomposition:
- Package reset_seq_pkg holds:
  - FSM state encoding (HOLD=0, RELEASE=1, WAIT_ACK=2, GAP=3, RUN=4);
  - RETRY_CNT_W=4 and its saturation constant.
- One sub-module, debounce_sync:
  - parameter DEBOUNCE_CYCLES; ports clk, sys_rstn, din, dout;
  - contains the 2-flop synchroniser plus debounce counter.
- The sys_rstn deassert synchroniser stays inline.

Test Plan (N_STAGES=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=4, STAGE_GAP=2, ACK_TIMEOUT=16):
- Nominal bring-up: release sys_rstn, ack each stage 3 cycles after its release -> stage_rstn_out goes 001, 011, 111 in order; all_ready=1; timeout_err=0; retry_cnt=0.
- Timeout: never assert stage_ready[1] -> 16 cycles after stage 1 release, timeout_err=1, retry_cnt=1, stage_rstn_out=000, sequence restarts from stage 0.
- User reset glitch then press: pulse user_rst for 2 cycles -> no effect. Hold it 10 cycles in RUN -> all_ready=0, stage_rstn_out=000. Stays in HOLD until user_rst has been low for 4+ synchroniser cycles, then re-sequences; retry_cnt unchanged.
- Ready loss: in RUN, drop stage_ready[2] for 1 cycle -> HOLD, retry_cnt+1, full re-sequence.
- Async reset mid-sequence: assert sys_rstn in WAIT_ACK for stage 1 -> stage_rstn_out=000 within the same cycle (no clock edge needed); timeout_err and retry_cnt=0.
- Saturation: force 20 consecutive timeouts -> retry_cnt holds at 15.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the Tx reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_RELEASE  = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_GAP      = 3'd3,
    ST_RUN      = 3'd4
  } seq_state_e;

  localparam int unsigned RETRY_CNT_W = 4;
  localparam logic [RETRY_CNT_W-1:0] RETRY_CNT_SAT = {RETRY_CNT_W{1'b1}};

  // Saturating increment of the re-sequence counter.
  function automatic logic [RETRY_CNT_W-1:0] retry_inc(input logic [RETRY_CNT_W-1:0] c);
    return (c == RETRY_CNT_SAT) ? c : c + RETRY_CNT_W'(1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a level debouncer for an asynchronous button.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic sys_rstn,
  input  logic din,
  output logic dout
);

  localparam int unsigned DB_MAX = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES : 1;
  localparam int unsigned CNT_W  = $clog2(DB_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_MAX - 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Output flips only after DB_MAX consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      dout      <= 1'b0;
    end else begin
      sync_meta <= din;
      sync_q    <= sync_meta;
      if (sync_q != dout) begin
        if (cnt == CNT_LAST) begin
          dout <= sync_q;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-stage Tx resets in order, one stage at a time, gated on each stage's ready ack.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_STAGES        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned ACK_TIMEOUT     = 4096
) (
  input  logic                   clk,
  input  logic                   sys_rstn,
  input  logic                   user_rst,
  input  logic [N_STAGES-1:0]    stage_ready,
  output logic [N_STAGES-1:0]    stage_rstn_out,
  output logic                   all_ready,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [RETRY_CNT_W-1:0] retry_cnt
);

  localparam int unsigned MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CNT_MAX = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned K_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(N_STAGES - 1);

  logic                   rst_meta;
  logic                   rst_sync_n;
  logic                   user_db;
  logic                   user_db_q;
  logic                   user_rise;
  seq_state_e             state_q, state_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_STAGES-1:0]    rstn_d;
  logic                   terr_d;
  logic [RETRY_CNT_W-1:0] retry_d;
  logic                   go_hold;
  logic                   bump;
  logic                   set_terr;
  logic                   advance;
  logic                   lost_lower;

  debounce_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_user_db (
    .clk      (clk),
    .sys_rstn (sys_rstn),
    .din      (user_rst),
    .dout     (user_db)
  );

  // Async-assert, sync-deassert copy of sys_rstn that enables the FSM.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  assign user_rise = user_db & ~user_db_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    rstn_d     = stage_rstn_out;
    terr_d     = timeout_err;
    retry_d    = retry_cnt;
    go_hold    = 1'b0;
    bump       = 1'b0;
    set_terr   = 1'b0;
    advance    = 1'b0;
    lost_lower = 1'b0;

    for (int unsigned j = 0; j < N_STAGES; j++) begin
      if ((K_W'(j) < k_q) && !stage_ready[j]) lost_lower = 1'b1;
    end

    case (state_q)
      ST_HOLD: begin
        k_d    = '0;
        rstn_d = '0;
        if (cnt_q >= HOLD_LAST) begin
          if (!user_db) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        rstn_d[k_q] = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (lost_lower) begin
          go_hold = 1'b1;
          bump    = 1'b1;
        end else if (stage_ready[k_q]) begin
          if (STAGE_GAP == 0) begin
            advance = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end
        end else if (cnt_q == ACK_LAST) begin
          go_hold  = 1'b1;
          bump     = 1'b1;
          set_terr = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (lost_lower) begin
          go_hold = 1'b1;
          bump    = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!(&stage_ready)) begin
          go_hold = 1'b1;
          bump    = 1'b1;
        end
      end
      default: go_hold = 1'b1;
    endcase

    if (advance) begin
      cnt_d = '0;
      if (k_q == K_LAST) begin
        state_d = ST_RUN;
      end else begin
        k_d     = k_q + K_W'(1);
        state_d = ST_RELEASE;
      end
    end

    // A fresh user press overrides everything and is not counted as a retry.
    if (user_rise) begin
      go_hold  = 1'b1;
      bump     = 1'b0;
      set_terr = 1'b0;
    end

    if (go_hold) begin
      state_d = ST_HOLD;
      k_d     = '0;
      cnt_d   = '0;
      rstn_d  = '0;
    end
    if (set_terr) terr_d  = 1'b1;
    if (bump)     retry_d = retry_inc(retry_cnt);
  end

  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q        <= ST_HOLD;
      k_q            <= '0;
      cnt_q          <= '0;
      stage_rstn_out <= '0;
      all_ready      <= 1'b0;
      busy           <= 1'b1;
      timeout_err    <= 1'b0;
      retry_cnt      <= '0;
      user_db_q      <= 1'b0;
    end else begin
      user_db_q <= user_db;
      if (rst_sync_n) begin
        state_q        <= state_d;
        k_q            <= k_d;
        cnt_q          <= cnt_d;
        stage_rstn_out <= rstn_d;
        all_ready      <= (state_d == ST_RUN);
        busy           <= (state_d != ST_RUN);
        timeout_err    <= terr_d;
        retry_cnt      <= retry_d;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: vector table plus hand-written corner-case sequences.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       sys_rstn;
  logic       user_rst;
  logic [2:0] stage_ready;
  logic [2:0] stage_rstn_out;
  logic       all_ready;
  logic       busy;
  logic       timeout_err;
  logic [3:0] retry_cnt;

  logic [2:0] blk;
  logic [2:0] drop;
  logic [1:0] ack_cnt [3];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] blk;
    logic [2:0] rstn;
    logic       all_rdy;
    logic       bsy;
    logic       terr;
    logic [3:0] retry;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_STAGES        (3),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (4),
    .STAGE_GAP       (2),
    .ACK_TIMEOUT     (16)
  ) dut (
    .clk            (clk),
    .sys_rstn       (sys_rstn),
    .user_rst       (user_rst),
    .stage_ready    (stage_ready),
    .stage_rstn_out (stage_rstn_out),
    .all_ready      (all_ready),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .retry_cnt      (retry_cnt)
  );

  // Stage model: ready a few cycles after its reset releases, unless blocked or dropped.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!stage_rstn_out[i]) ack_cnt[i] <= 2'd0;
      else if (ack_cnt[i] != 2'd3) ack_cnt[i] <= ack_cnt[i] + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++)
      stage_ready[i] = (ack_cnt[i] == 2'd3) && !blk[i] && !drop[i];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge and check the invariants that hold every cycle.
  task automatic tick();
    logic legal;
    @(negedge clk);
    if (sys_rstn) begin
      legal = (stage_rstn_out inside {3'b000, 3'b001, 3'b011, 3'b111});
      check("rstn_order", 32'(legal), 32'd1);
      check("ready_vs_busy", 32'(all_ready ^ busy), 32'd1);
    end
  endtask

  task automatic wait_out(input string nm, input logic [2:0] r, input logic a, input int lim);
    int n = 0;
    while ((stage_rstn_out !== r || all_ready !== a) && n < lim) begin
      tick();
      n++;
    end
    check(nm, 32'({stage_rstn_out, all_ready}), 32'({r, a}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    sys_rstn = 1'b0;
    user_rst = 1'b0;
    blk      = 3'b000;
    drop     = 3'b000;

    //            blk     rstn    all   busy  terr  retry
    vecs[0] = '{3'b000, 3'b001, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[1] = '{3'b000, 3'b011, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[2] = '{3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[3] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 4'd0};
    vecs[4] = '{3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[5] = '{3'b010, 3'b001, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[6] = '{3'b010, 3'b011, 1'b0, 1'b1, 1'b0, 4'd1};
    vecs[7] = '{3'b010, 3'b000, 1'b0, 1'b1, 1'b1, 4'd2};
    vecs[8] = '{3'b000, 3'b001, 1'b0, 1'b1, 1'b1, 4'd2};
    vecs[9] = '{3'b000, 3'b111, 1'b1, 1'b0, 1'b1, 4'd2};

    repeat (3) @(negedge clk);
    check("rst_rstn",  32'(stage_rstn_out), 32'h0);
    check("rst_all",   32'(all_ready),      32'h0);
    check("rst_busy",  32'(busy),           32'h1);
    check("rst_terr",  32'(timeout_err),    32'h0);
    check("rst_retry", 32'(retry_cnt),      32'h0);

    sys_rstn = 1'b1;
    for (int v = 0; v < 10; v++) begin
      blk = vecs[v].blk;
      wait_out($sformatf("vec%0d_out", v), vecs[v].rstn, vecs[v].all_rdy, 200);
      check($sformatf("vec%0d_busy", v),  32'(busy),        32'(vecs[v].bsy));
      check($sformatf("vec%0d_terr", v),  32'(timeout_err), 32'(vecs[v].terr));
      check($sformatf("vec%0d_retry", v), 32'(retry_cnt),   32'(vecs[v].retry));
    end

    // Exact ack-timeout latency measured from the stage 1 release.
    blk = 3'b010;
    wait_out("to_rel1", 3'b011, 1'b0, 200);
    n = 0;
    while (stage_rstn_out !== 3'b000 && n < 100) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n),           32'd16);
    check("to_retry",   32'(retry_cnt),   32'd4);
    check("to_terr",    32'(timeout_err), 32'd1);
    blk = 3'b000;
    wait_out("to_rerun", 3'b111, 1'b1, 300);

    // Single-cycle loss of stage 2 ready while running.
    drop = 3'b100;
    tick();
    drop = 3'b000;
    check("loss_rstn",  32'(stage_rstn_out), 32'h0);
    check("loss_all",   32'(all_ready),      32'h0);
    check("loss_retry", 32'(retry_cnt),      32'd5);
    wait_out("loss_rerun", 3'b111, 1'b1, 300);
    check("loss_retry2", 32'(retry_cnt), 32'd5);

    // Short user glitch is filtered; a long press forces HOLD without a retry count.
    user_rst = 1'b1;
    repeat (2) tick();
    user_rst = 1'b0;
    repeat (10) tick();
    check("glitch_all",  32'(all_ready),      32'h1);
    check("glitch_rstn", 32'(stage_rstn_out), 32'h7);
    user_rst = 1'b1;
    repeat (10) tick();
    check("press_all",  32'(all_ready),      32'h0);
    check("press_rstn", 32'(stage_rstn_out), 32'h0);
    user_rst = 1'b0;
    repeat (3) tick();
    check("press_held", 32'(stage_rstn_out), 32'h0);
    wait_out("press_rerun", 3'b111, 1'b1, 300);
    check("press_retry", 32'(retry_cnt), 32'd5);

    // Asynchronous reset while waiting on stage 1.
    blk = 3'b010;
    wait_out("arst_rel1", 3'b011, 1'b0, 200);
    repeat (3) tick();
    #2 sys_rstn = 1'b0;
    #1;
    check("arst_rstn",  32'(stage_rstn_out), 32'h0);
    check("arst_all",   32'(all_ready),      32'h0);
    check("arst_busy",  32'(busy),           32'h1);
    check("arst_terr",  32'(timeout_err),    32'h0);
    check("arst_retry", 32'(retry_cnt),      32'h0);

    // Twenty consecutive timeouts saturate the retry counter.
    repeat (2) @(negedge clk);
    sys_rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_out($sformatf("sat%0d_rel", i), 3'b011, 1'b0, 200);
      wait_out($sformatf("sat%0d_to", i),  3'b000, 1'b0, 200);
    end
    check("sat_retry", 32'(retry_cnt),   32'd15);
    check("sat_terr",  32'(timeout_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
